// File: rtl/dk_input_pkg.sv
// Shared constants and types for the Donkey Kong input mapper.
// Holds the 9-bit {ext,code} PS/2 key map, bit indices for the joystick
// word and output vectors, the held-key state struct, the coin FSM state
// enum and the direction remap helper.
package dk_input_pkg;

   // PS/2 key-event bus fields
   localparam int unsigned PS2_W       = 11;
   localparam int unsigned PS2_TOGGLE  = 10;
   localparam int unsigned PS2_PRESSED = 9;
   localparam int unsigned PS2_EXT     = 8;

   // Key map, {ext,code}; arrow keys match on code alone
   localparam logic [8:0] KC_UP       = 9'h075;
   localparam logic [8:0] KC_DOWN     = 9'h072;
   localparam logic [8:0] KC_LEFT     = 9'h06B;
   localparam logic [8:0] KC_RIGHT    = 9'h074;
   localparam logic [8:0] KC_JUMP1    = 9'h029;
   localparam logic [8:0] KC_JUMP2    = 9'h014;
   localparam logic [8:0] KC_START1A  = 9'h005;
   localparam logic [8:0] KC_START1B  = 9'h016;
   localparam logic [8:0] KC_START2A  = 9'h006;
   localparam logic [8:0] KC_START2B  = 9'h01E;
   localparam logic [8:0] KC_COIN1    = 9'h02E;
   localparam logic [8:0] KC_COIN2    = 9'h036;
   localparam logic [8:0] KC_P2_UP    = 9'h02D;
   localparam logic [8:0] KC_P2_DOWN  = 9'h02B;
   localparam logic [8:0] KC_P2_LEFT  = 9'h023;
   localparam logic [8:0] KC_P2_RIGHT = 9'h034;
   localparam logic [8:0] KC_P2_JUMP  = 9'h01C;

   // Joystick word bit indices
   localparam int unsigned JOY_W      = 16;
   localparam int unsigned J_RIGHT    = 0;
   localparam int unsigned J_LEFT     = 1;
   localparam int unsigned J_DOWN     = 2;
   localparam int unsigned J_UP       = 3;
   localparam int unsigned J_JUMP     = 4;
   localparam int unsigned J_START1   = 5;
   localparam int unsigned J_START2   = 6;

   // Player output vector {jump,right,left,down,up}
   localparam int unsigned DIR_W      = 5;
   localparam int unsigned O_UP       = 0;
   localparam int unsigned O_DOWN     = 1;
   localparam int unsigned O_LEFT     = 2;
   localparam int unsigned O_RIGHT    = 3;
   localparam int unsigned O_JUMP     = 4;

   // Held state of every mapped key (1 = held)
   typedef struct packed {
      logic p1_up;
      logic p1_down;
      logic p1_left;
      logic p1_right;
      logic p1_jump_a;
      logic p1_jump_b;
      logic start1_a;
      logic start1_b;
      logic start2_a;
      logic start2_b;
      logic coin_a;
      logic coin_b;
      logic p2_up;
      logic p2_down;
      logic p2_left;
      logic p2_right;
      logic p2_jump;
   } key_state_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_state_t;

   // Build an active-high player vector, rotating directions when horizontal
   function automatic logic [DIR_W-1:0] compose_dirs(
      input logic up,
      input logic down,
      input logic left,
      input logic right,
      input logic jump,
      input logic rotate
   );
      logic [DIR_W-1:0] v;
      v          = '0;
      v[O_UP]    = rotate ? left  : up;
      v[O_DOWN]  = rotate ? right : down;
      v[O_LEFT]  = rotate ? down  : left;
      v[O_RIGHT] = rotate ? up    : right;
      v[O_JUMP]  = jump;
      return v;
   endfunction

endpackage

// File: rtl/dk_coin_pulser.sv
// Fixed-width, rate-limited coin pulse generator.
// Ports:
//   clk_sys  - system clock
//   reset    - synchronous, active-high
//   coin_src - level coin request; only rising edges trigger
//   o_coin_n - active-low coin line, low for COIN_PULSE_CYCLES per pulse,
//              then high for at least COIN_GAP_CYCLES
// At most one further request is queued while a pulse or gap is running.
module dk_coin_pulser
   import dk_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE_CYCLES = 2457600,
   parameter int unsigned COIN_GAP_CYCLES   = 2457600
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic coin_src,
   output logic o_coin_n
);

   localparam int unsigned CNT_MAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                     COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(COIN_GAP_CYCLES - 1);

   coin_state_t      state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             pending, pending_nxt;
   logic             coin_src_q;
   logic             rise_c;

   assign rise_c = coin_src & ~coin_src_q;

   // Next-state logic
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      pending_nxt = pending;
      case (state)
         IDLE: begin
            if (rise_c) begin
               state_nxt = PULSE;
               cnt_nxt   = '0;
            end
         end
         PULSE: begin
            if (rise_c) pending_nxt = 1'b1;
            if (cnt == PULSE_LAST) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt == GAP_LAST) begin
               // a rise coinciding with the gap end counts as seen in IDLE
               if (pending || rise_c) begin
                  state_nxt   = PULSE;
                  cnt_nxt     = '0;
                  pending_nxt = 1'b0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               if (rise_c) pending_nxt = 1'b1;
            end
         end
         default: begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            pending_nxt = 1'b0;
         end
      endcase
   end

   // State register and registered coin output
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         pending    <= 1'b0;
         coin_src_q <= 1'b0;
         o_coin_n   <= 1'b1;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pending    <= pending_nxt;
         coin_src_q <= coin_src;
         o_coin_n   <= (state_nxt != PULSE);
      end
   end

endmodule

// File: rtl/dk_input_mapper.sv
// Maps PS/2 key events and the hps_io joystick word onto the active-low
// Donkey Kong arcade control lines.
// Ports:
//   clk_sys    - system clock, 24.576 MHz
//   reset      - synchronous, active-high
//   ps2_key    - [10] toggle strobe, [9] pressed, [8] extended, [7:0] code
//   joy        - merged joystick: [0] R [1] L [2] D [3] U [4] jump
//                [5] start1 [6] start2
//   rotate     - 1 = horizontal orientation, directions remapped
//   o_p1_n     - player 1 {jump,right,left,down,up}, active-low
//   o_p2_n     - player 2, same layout
//   o_start1_n - start 1, active-low
//   o_start2_n - start 2, active-low
//   o_coin_n   - coin pulse, active-low
module dk_input_mapper
   import dk_input_pkg::*;
#(
   parameter int unsigned COIN_PULSE_CYCLES = 2457600,
   parameter int unsigned COIN_GAP_CYCLES   = 2457600
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [PS2_W-1:0] ps2_key,
   input  logic [JOY_W-1:0] joy,
   input  logic             rotate,
   output logic [DIR_W-1:0] o_p1_n,
   output logic [DIR_W-1:0] o_p2_n,
   output logic             o_start1_n,
   output logic             o_start2_n,
   output logic             o_coin_n
);

   logic       old_toggle;
   key_state_t keys, keys_nxt;
   logic       event_c;
   logic       arrow_c;
   logic [8:0] key_code_c;
   logic       pressed_c;
   logic       coin_src_c;
   logic       unused_joy;

   assign unused_joy = ^joy[JOY_W-1:J_START2+1];

   assign event_c   = ps2_key[PS2_TOGGLE] != old_toggle;
   assign pressed_c = ps2_key[PS2_PRESSED];

   // Arrow keys ignore the extended flag: fold them onto ext=0
   assign arrow_c    = (ps2_key[7:0] == KC_UP[7:0])   ||
                       (ps2_key[7:0] == KC_DOWN[7:0]) ||
                       (ps2_key[7:0] == KC_LEFT[7:0]) ||
                       (ps2_key[7:0] == KC_RIGHT[7:0]);
   assign key_code_c = {ps2_key[PS2_EXT] & ~arrow_c, ps2_key[7:0]};

   // Key-state update on a toggle event
   always_comb begin
      keys_nxt = keys;
      if (event_c) begin
         case (key_code_c)
            KC_UP:       keys_nxt.p1_up     = pressed_c;
            KC_DOWN:     keys_nxt.p1_down   = pressed_c;
            KC_LEFT:     keys_nxt.p1_left   = pressed_c;
            KC_RIGHT:    keys_nxt.p1_right  = pressed_c;
            KC_JUMP1:    keys_nxt.p1_jump_a = pressed_c;
            KC_JUMP2:    keys_nxt.p1_jump_b = pressed_c;
            KC_START1A:  keys_nxt.start1_a  = pressed_c;
            KC_START1B:  keys_nxt.start1_b  = pressed_c;
            KC_START2A:  keys_nxt.start2_a  = pressed_c;
            KC_START2B:  keys_nxt.start2_b  = pressed_c;
            KC_COIN1:    keys_nxt.coin_a    = pressed_c;
            KC_COIN2:    keys_nxt.coin_b    = pressed_c;
            KC_P2_UP:    keys_nxt.p2_up     = pressed_c;
            KC_P2_DOWN:  keys_nxt.p2_down   = pressed_c;
            KC_P2_LEFT:  keys_nxt.p2_left   = pressed_c;
            KC_P2_RIGHT: keys_nxt.p2_right  = pressed_c;
            KC_P2_JUMP:  keys_nxt.p2_jump   = pressed_c;
            default: ;
         endcase
      end
   end

   // Coin request from the held key state; the pulser edge-detects it
   assign coin_src_c = keys.start1_a | keys.start1_b | keys.start2_a |
                       keys.start2_b | keys.coin_a | keys.coin_b |
                       joy[J_START1] | joy[J_START2];

   // Key registers and inverted control outputs; outputs use the updated
   // key state so an event shows up right after the edge that samples it
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         old_toggle <= ps2_key[PS2_TOGGLE];
         keys       <= '0;
         o_p1_n     <= '1;
         o_p2_n     <= '1;
         o_start1_n <= 1'b1;
         o_start2_n <= 1'b1;
      end else begin
         old_toggle <= ps2_key[PS2_TOGGLE];
         keys       <= keys_nxt;
         o_p1_n     <= ~compose_dirs(keys_nxt.p1_up    | joy[J_UP],
                                     keys_nxt.p1_down  | joy[J_DOWN],
                                     keys_nxt.p1_left  | joy[J_LEFT],
                                     keys_nxt.p1_right | joy[J_RIGHT],
                                     keys_nxt.p1_jump_a | keys_nxt.p1_jump_b |
                                     joy[J_JUMP],
                                     rotate);
         o_p2_n     <= ~compose_dirs(keys_nxt.p2_up    | joy[J_UP],
                                     keys_nxt.p2_down  | joy[J_DOWN],
                                     keys_nxt.p2_left  | joy[J_LEFT],
                                     keys_nxt.p2_right | joy[J_RIGHT],
                                     keys_nxt.p2_jump  | joy[J_JUMP],
                                     rotate);
         o_start1_n <= ~(keys_nxt.start1_a | keys_nxt.start1_b | joy[J_START1]);
         o_start2_n <= ~(keys_nxt.start2_a | keys_nxt.start2_b | joy[J_START2]);
      end
   end

   dk_coin_pulser #(
      .COIN_PULSE_CYCLES (COIN_PULSE_CYCLES),
      .COIN_GAP_CYCLES   (COIN_GAP_CYCLES)
   ) u_coin_pulser (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .coin_src (coin_src_c),
      .o_coin_n (o_coin_n)
   );

endmodule

// File: tb/tb_dk_input_mapper.sv
// Directed bench for dk_input_mapper with a short coin pulse (P=8, G=4).
module tb_dk_input_mapper;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic [10:0] ps2_key;
   logic [15:0] joy;
   logic        rotate;
   logic [4:0]  o_p1_n;
   logic [4:0]  o_p2_n;
   logic        o_start1_n;
   logic        o_start2_n;
   logic        o_coin_n;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk_sys = ~clk_sys;

   dk_input_mapper #(
      .COIN_PULSE_CYCLES (8),
      .COIN_GAP_CYCLES   (4)
   ) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .ps2_key    (ps2_key),
      .joy        (joy),
      .rotate     (rotate),
      .o_p1_n     (o_p1_n),
      .o_p2_n     (o_p2_n),
      .o_start1_n (o_start1_n),
      .o_start2_n (o_start2_n),
      .o_coin_n   (o_coin_n)
   );

   task automatic check_eq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one edge, land 1 time unit after it
   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic ps2_ev(input logic pr, input logic ext, input logic [7:0] code);
      ps2_key = {~ps2_key[10], pr, ext, code};
   endtask

   // Optional key event, one edge, then check the coin line
   task automatic coin_step(input logic ev, input logic pr, input logic [7:0] code,
                            input logic exp, input string tag);
      if (ev) ps2_ev(pr, 1'b0, code);
      tick();
      check_eq(tag, o_coin_n, exp);
   endtask

   task automatic coin_run(input logic exp, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         check_eq(tag, o_coin_n, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_p1"}, o_p1_n, 32'h1F);
      check_eq({tag, "_p2"}, o_p2_n, 32'h1F);
      check_eq({tag, "_s1"}, o_start1_n, 32'h1);
      check_eq({tag, "_s2"}, o_start2_n, 32'h1);
      check_eq({tag, "_coin"}, o_coin_n, 32'h1);
   endtask

   initial begin
      reset   = 1'b1;
      ps2_key = 11'h400;
      joy     = '0;
      rotate  = 1'b0;
      repeat (3) tick();
      check_idle_outputs("in_reset");
      reset = 1'b0;
      tick();
      check_idle_outputs("post_reset");
      repeat (3) tick();
      check_idle_outputs("no_phantom");

      // Arrow up, extended code, both orientations
      ps2_ev(1'b1, 1'b1, 8'h75); tick(); check_eq("up_press", o_p1_n, 32'h1E);
      ps2_ev(1'b0, 1'b1, 8'h75); tick(); check_eq("up_release", o_p1_n, 32'h1F);
      ps2_ev(1'b1, 1'b0, 8'h75); tick(); check_eq("up_noext", o_p1_n, 32'h1E);
      ps2_ev(1'b0, 1'b0, 8'h75); tick();
      rotate = 1'b1;
      ps2_ev(1'b1, 1'b1, 8'h75); tick(); check_eq("up_rot_right", o_p1_n, 32'h17);
      ps2_ev(1'b0, 1'b1, 8'h75); tick(); check_eq("up_rot_rel", o_p1_n, 32'h1F);

      // Joystick right under rotation lands on down, both players
      joy = 16'h0001; tick();
      check_eq("joy_rot_p1", o_p1_n, 32'h1D);
      check_eq("joy_rot_p2", o_p2_n, 32'h1D);
      joy = '0; rotate = 1'b0; tick();
      check_eq("joy_clear", o_p1_n, 32'h1F);

      // Player 2 keys; extended variant of a non-arrow code is ignored
      ps2_ev(1'b1, 1'b1, 8'h2D); tick(); check_eq("p2_ext_ignored", o_p2_n, 32'h1F);
      ps2_ev(1'b1, 1'b0, 8'h2D); tick(); check_eq("p2_up", o_p2_n, 32'h1E);
      ps2_ev(1'b1, 1'b0, 8'h1C); tick(); check_eq("p2_up_jump", o_p2_n, 32'h0E);
      ps2_ev(1'b0, 1'b0, 8'h2D); tick();
      ps2_ev(1'b0, 1'b0, 8'h1C); tick(); check_eq("p2_rel", o_p2_n, 32'h1F);
      check_eq("p2_p1_quiet", o_p1_n, 32'h1F);

      // Jump: joy and key ORed; the two jump keys are independent
      joy = 16'h0010;
      ps2_ev(1'b1, 1'b0, 8'h29); tick(); check_eq("jump_both", o_p1_n, 32'h0F);
      joy = '0; tick(); check_eq("jump_key_hold", o_p1_n, 32'h0F);
      ps2_ev(1'b0, 1'b0, 8'h29); tick(); check_eq("jump_released", o_p1_n, 32'h1F);
      ps2_ev(1'b1, 1'b0, 8'h29); tick();
      ps2_ev(1'b1, 1'b0, 8'h14); tick();
      ps2_ev(1'b0, 1'b0, 8'h29); tick(); check_eq("jump_b_hold", o_p1_n, 32'h0F);
      ps2_ev(1'b0, 1'b0, 8'h14); tick(); check_eq("jump_b_rel", o_p1_n, 32'h1F);

      // Coin: 8 low, gap of 4, queued press 2 cycles into the gap
      coin_step(1'b1, 1'b1, 8'h2E, 1'b1, "c1_edge_k");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b0, "c1_low_first");
      coin_run(1'b0, 7, "c1_low");
      coin_step(1'b0, 1'b0, 8'h00, 1'b1, "c1_gap0");
      coin_step(1'b0, 1'b0, 8'h00, 1'b1, "c1_gap1");
      coin_step(1'b1, 1'b1, 8'h2E, 1'b1, "c1_gap2");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b1, "c1_gap3");
      coin_run(1'b0, 8, "c2_low");
      coin_run(1'b1, 6, "c2_after");

      // Three rises inside one pulse queue exactly one more pulse
      coin_step(1'b1, 1'b1, 8'h2E, 1'b1, "r3_edge");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b0, "r3_p1");
      coin_step(1'b1, 1'b1, 8'h2E, 1'b0, "r3_p2");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b0, "r3_p3");
      coin_step(1'b1, 1'b1, 8'h2E, 1'b0, "r3_p4");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b0, "r3_p5");
      coin_step(1'b1, 1'b1, 8'h36, 1'b0, "r3_p6");
      coin_step(1'b1, 1'b0, 8'h36, 1'b0, "r3_p7");
      coin_step(1'b0, 1'b0, 8'h00, 1'b0, "r3_p8");
      coin_run(1'b1, 4, "r3_gap");
      coin_run(1'b0, 8, "r3_extra");
      coin_run(1'b1, 10, "r3_done");

      // Start1 held on joystick: single pulse, start asserted throughout
      joy = 16'h0020;
      for (int i = 0; i < 40; i++) begin
         tick();
         check_eq("s1_held", o_start1_n, 32'h0);
         check_eq("s1_coin", o_coin_n, (i < 8) ? 32'h0 : 32'h1);
      end
      joy = '0; tick();
      check_eq("s1_release", o_start1_n, 32'h1);
      check_eq("s1_coin_idle", o_coin_n, 32'h1);

      // Reset in pulse cycle 3 with a request queued
      coin_step(1'b1, 1'b1, 8'h2E, 1'b1, "rst_edge");
      coin_step(1'b1, 1'b0, 8'h2E, 1'b0, "rst_p1");
      coin_step(1'b1, 1'b1, 8'h2E, 1'b0, "rst_p2");
      coin_step(1'b0, 1'b0, 8'h00, 1'b0, "rst_p3");
      reset = 1'b1;
      tick(); check_eq("rst_coin_high", o_coin_n, 32'h1);
      reset = 1'b0;
      ps2_ev(1'b0, 1'b0, 8'h2E);
      coin_run(1'b1, 20, "rst_no_pulse");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
